// File: rtl/scan_digit_sequencer.sv
// Multiplex scan for an eight-digit seven-segment display, with double-buffered
// score updates that are committed only when the scan index wraps from 7 to 0.
module scan_digit_sequencer #(
  parameter int unsigned DIV = 100000,
  parameter bit          LZB = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] score_bcd,
  input  logic        score_load,
  output logic [2:0]  refreshcounter,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam int unsigned NDIG = 8;

  logic [PW-1:0] prescaler;
  logic [31:0]   display;
  logic [31:0]   pending;
  logic          pend_flag;
  logic          tick;
  logic          commit;

  always_comb begin
    tick   = (prescaler == PRE_LAST);
    commit = tick && (refreshcounter == 3'd7);
  end

  // Prescaler, scan index, frame pulse and the two score buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler      <= '0;
      refreshcounter <= 3'd0;
      display        <= 32'd0;
      pending        <= 32'd0;
      pend_flag      <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= commit;
      if (tick) begin
        prescaler      <= '0;
        refreshcounter <= refreshcounter + 3'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      // A load landing on the commit cycle bypasses the pending buffer.
      if (score_load) begin
        pending <= score_bcd;
        if (commit) begin
          display   <= score_bcd;
          pend_flag <= 1'b0;
        end else begin
          pend_flag <= 1'b1;
        end
      end else if (commit && pend_flag) begin
        display   <= pending;
        pend_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    digit = display[{refreshcounter, 2'b00} +: 4];
  end

  // Blank when this digit and every more-significant digit are zero.
  always_comb begin
    blank = 1'b0;
    if (LZB && (refreshcounter != 3'd0)) begin
      blank = 1'b1;
      for (int k = 1; k < NDIG; k++) begin
        if ((3'(k) >= refreshcounter) && (display[4*k +: 4] != 4'd0)) begin
          blank = 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/scan_digit_sequencer.md
# scan_digit_sequencer

Drives the eight-digit seven-segment scoreboard's multiplex scan. It produces the 3-bit `refreshcounter` that the downstream anode decoder turns into an active-low anode enable, where 0 selects the rightmost digit. It also produces the matching 4-bit BCD digit and a blank flag for the cathode decoder. Score updates are double-buffered and committed only at a frame boundary, so a displayed frame never mixes old and new digits.

## Interface
- `DIV`, 100000: clock cycles per digit slot (100 MHz gives a 1 kHz digit rate). Legal range is ≥ 2.
- `LZB`, 1: leading-zero blanking enable (1 = on).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `score_bcd`  in  32  eight packed BCD digits; [3:0] is digit 0 (rightmost), [31:28] is digit 7.
- `score_load`  in  1  one-cycle strobe; captures `score_bcd` into the pending buffer.
- `refreshcounter`  out  3  current digit index, registered; feeds the anode decoder.
- `digit`  out  4  BCD value for the current index.
- `blank`  out  1  1 = current digit must be dark.
- `frame_done`  out  1  one-cycle pulse when the index wraps from 7 to 0.

## Operation
- **Prescaler:** counts 0..DIV-1 and then wraps.
  - `tick` is asserted in the cycle the prescaler equals DIV-1.
  - Prescaler width is clog2(DIV).
- **Index counter:** `refreshcounter` increments by 1 on `tick` and wraps 7→0 (mod-8, no terminal state).
- **Buffering:**
  - The pending register and the pending flag load on `score_load`.
  - The display register is the only source for `digit` and `blank`.
  - Commit happens on a tick with `refreshcounter`==7: if the pending flag is set, the display register takes the pending value and the flag clears.
- **Load coincident with commit:** the incoming `score_bcd` is committed directly to the display register and the pending flag ends cleared.
- **Load while pending:** the later value overwrites the earlier one. Only the latest load is shown.
- **digit:** combinational select of display[4i+3:4i], where i = `refreshcounter`. It is aligned with `refreshcounter` with zero offset.
- **blank:** 1 when all three hold:
  - `LZB`=1;
  - i ≠ 0;
  - every display nibble at index ≥ i is zero.
  
  Digit 0 is never blanked, so a score of 0 shows a single "0".
- **Nibbles > 9:** passed through unmodified. Blanking treats them as nonzero.
- **frame_done:** registered, high for exactly one cycle. It is coincident with `refreshcounter` becoming 0 and with the commit taking effect.

## Timing
- **Reset values:** prescaler=0, `refreshcounter`=0, display=0, pending=0, pending flag=0, `frame_done`=0. This gives `digit`=0 and `blank`=0.
- **Reset mid-frame:** all state returns to the reset values on the next edge and any pending load is discarded. The scan resumes from index 0, with the first advance DIV cycles after reset deasserts.
- **Digit slot:** each index is held for exactly DIV cycles; a full frame takes 8·DIV cycles.
- **Update latency:** a load appears at the first frame boundary after it.
  - Worst case is 8·DIV cycles.
  - Best case: a load in the commit cycle is visible on the next edge.
- **Sampling:** `score_load` is sampled every cycle, independent of `tick`. Loads are never dropped.

## Test plan
- **Reset and scan order:** DIV=4, assert reset for 3 cycles, then release.
  - `refreshcounter` steps 0,1,…,7,0, each value held 4 cycles.
  - `frame_done` pulses once per 32 cycles, at the 7→0 edge.
  - Outputs are 0 during reset.
- **Double buffering:** with display 0x00000000, load 0x12345678 while index=3.
  - Indices 3..7 still show 0, with `blank`=1 for LZB=1.
  - From the next index 0, `digit` reads 8,7,6,5,4,3,2,1 with `blank`=0.
- **Leading-zero blanking:** load 0x00000305, then wait one frame.
  - Indices 0–2 show `blank`=0, with `digit`=5,0,3.
  - Indices 3–7 show `blank`=1.
  - Repeat with LZB=0: `blank`=0 everywhere.
- **Zero score:** load 0x00000000. Index 0 shows `blank`=0 and `digit`=0; indices 1–7 show `blank`=1.
- **Simultaneous load and commit:**
  - Load 0x11111111 mid-frame, then load 0x22222222 in the commit cycle (tick with index 7).
  - The next frame shows all 2s and the pending flag is 0.
  - 0x11111111 is never displayed.
- **Reset during pending:** load 0x99999999 at index 4, assert reset at index 6.
  - After release, index 0 shows `digit`=0 and no 9s appear in subsequent frames.
